// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mul_pkg
// Description : Shared types and constants for the multiplier scheduler.
//               Holds the scheduler state encoding, the core width, the
//               fixed iteration wait and the width of the wait counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Width of the shared shift-and-add multiplier core.
    localparam int MUL_WIDTH = 32;

    // The core retires one multiplier bit per clock, so the worst case is
    // one iteration per bit of B regardless of its value.
    localparam int MUL_WAIT  = MUL_WIDTH;

    // Counter must be able to hold the value MUL_WAIT itself.
    localparam int CNT_W     = $clog2(MUL_WIDTH + 1);

    // Scheduler states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches upward from the
//               requester after i_last_grant, wrapping to 0, and returns the
//               first valid requester as a one-hot vector plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req_valid,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Two ordered passes: first the requesters above the last grant, then the
    // wrap-around ones up to and including the last grant. The first hit wins,
    // which gives strict rotation.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && (j > int'(i_last_grant)) && i_req_valid[j]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && (j <= int'(i_last_grant)) && i_req_valid[j]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(j);
            end
        end
    end

    // One-hot form of the winner, all zero when nobody asks.
    always_comb begin
        o_grant_any = w_found;
        o_grant_idx = w_idx;
        o_grant     = w_found ? (NREQ'(1) << w_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : mul_sched
// Description : Round-robin scheduler sharing one 32x32 shift-and-add
//               multiplier core between NREQ requesters. Accepts one operand
//               pair at a time, pulses the core load strobe, waits out the
//               core's worst-case iteration count and returns the 64-bit
//               product on a per-requester valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sched
    import mul_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = MUL_WIDTH    // must match the core width
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    mul_on,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_out
);

    localparam int               c_IDX_W = $clog2(NREQ);
    localparam logic [CNT_W-1:0] c_WAIT  = CNT_W'(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   r_grant;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic [2*WIDTH-1:0]   r_rsp_data;

    logic [NREQ-1:0]      w_arb_oh;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic                 w_arb_any;
    logic [NREQ-1:0]      w_grant_oh;
    logic                 w_rsp_hit;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;

    rr_arbiter #(
        .NREQ         (NREQ),
        .IDX_W        (c_IDX_W)
    ) u_arb (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_oh),
        .o_grant_idx  (w_arb_idx),
        .o_grant_any  (w_arb_any)
    );

    // Operand mux: pick the winning requester's slice of the packed buses.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_idx == c_IDX_W'(i)) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Registered grant as one-hot, and whether its owner accepts the response.
    always_comb begin
        w_grant_oh = NREQ'(1) << r_grant;
        w_rsp_hit  = |(rsp_ready & w_grant_oh);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; nothing is offered outside IDLE and
    // only the granted requester sees its response strobe.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        mul_on      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    req_ready   = w_arb_oh;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                mul_on      = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = w_grant_oh;
                if (w_rsp_hit) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture on accept, wait counter, product capture and
    // rotation pointer update when the response is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_last_grant <= c_IDX_W'(NREQ - 1);
            r_grant      <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_mul_a <= w_sel_a;
                        r_mul_b <= w_sel_b;
                        r_grant <= w_arb_idx;
                    end
                end
                LOAD: begin
                    r_cnt <= c_WAIT;
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        r_rsp_data <= mul_out;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (w_rsp_hit) begin
                        r_last_grant <= r_grant;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Operands stay on the core inputs from LOAD until the next accept.
    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign rsp_data = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sched
// Description : Scoreboard bench for mul_sched with a behavioural
//               shift-and-add core model alongside it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sched;

    localparam int NREQ  = 2;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready = '1;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  mul_on;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_out;

    mul_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mul_on    (mul_on),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out)
    );

    always #5 clk = ~clk;

    // Shift-and-add core: loads on 'on', then one multiplier bit per clock
    // until the multiplier register is empty. No reset.
    logic [2*WIDTH-1:0] core_acc    = '0;
    logic [2*WIDTH-1:0] core_mcand  = '0;
    logic [WIDTH-1:0]   core_mplier = '0;
    always @(posedge clk) begin
        if (mul_on) begin
            core_acc    <= '0;
            core_mcand  <= {{WIDTH{1'b0}}, mul_a};
            core_mplier <= mul_b;
        end else if (core_mplier != '0) begin
            if (core_mplier[0]) core_acc <= core_acc + core_mcand;
            core_mcand  <= core_mcand << 1;
            core_mplier <= core_mplier >> 1;
        end
    end
    assign mul_out = core_acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 idx;
        logic [2*WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    int   s_pass = 0, s_tot = 0;
    int   m_pass = 0, m_tot = 0;
    int   n_acc = 0, n_rsp = 0;
    bit   started = 0;
    int   last_rise = 0;
    bit   period_chk = 0;
    exp_t mon_e;
    int   mon_lat;
    logic [NREQ-1:0] mon_oh;

    function automatic bit chk(input string name, input logic [63:0] act, input logic [63:0] want);
        if (act !== want) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor: records accepts, checks latency and spacing of each response,
    // pops the scoreboard and compares on every response handshake.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            started = 0;
        end else begin
            if ((req_valid & req_ready) != '0) begin
                acc_q.push_back(cyc + 1);
                n_acc++;
            end
            if (rsp_valid != '0 && !started) begin
                started = 1;
                m_tot++;
                if (acc_q.size() == 0) begin
                    $display("FAIL rsp_latency: response with no accepted request (cycle %0d)", cyc);
                end else begin
                    mon_lat = cyc - acc_q.pop_front();
                    if (chk("rsp_latency", 64'(mon_lat), 64'd34)) m_pass++;
                end
                if (period_chk && last_rise != 0) begin
                    m_tot++;
                    if (chk("rsp_period", 64'(cyc - last_rise), 64'd36)) m_pass++;
                end
                last_rise = cyc;
            end
            if (!period_chk) last_rise = 0;
            if ((rsp_valid & rsp_ready) != '0) begin
                started = 0;
                n_rsp++;
                m_tot++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: got valid 0x%0h data 0x%0h, expected none", rsp_valid, rsp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.idx] = 1'b1;
                    if (chk("rsp_idx", 64'(rsp_valid), 64'(mon_oh))) m_pass++;
                    m_tot++;
                    if (chk("rsp_data", rsp_data, mon_e.data)) m_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_chk(input string name, input logic [63:0] act, input logic [63:0] want);
        s_tot++;
        if (chk(name, act, want)) s_pass++;
    endtask

    task automatic wait_acc(input int target, input int budget);
        int b;
        b = budget;
        while (n_acc < target && b > 0) begin
            tick();
            b--;
        end
        s_chk("accept_wait", 64'(n_acc >= target), 64'd1);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int b;
        b = budget;
        while (n_rsp < target && b > 0) begin
            tick();
            b--;
        end
        s_chk("response_wait", 64'(n_rsp >= target), 64'd1);
    endtask

    task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] want);
        int ba, br;
        ba = n_acc;
        br = n_rsp;
        exp_q.push_back('{i, want});
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i] = 1'b1;
        wait_acc(ba + 1, 20);
        req_valid = '0;
        wait_rsp(br + 1, 80);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ba, br, b;
        logic seen;

        rst = 1'b1;
        rsp_ready = '1;
        repeat (3) tick();
        s_chk("rst_req_ready", 64'(req_ready), 64'd0);
        s_chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        s_chk("rst_rsp_data",  rsp_data, 64'd0);
        s_chk("rst_mul_on",    64'(mul_on), 64'd0);
        s_chk("rst_mul_a",     64'(mul_a), 64'd0);
        s_chk("rst_mul_b",     64'(mul_b), 64'd0);
        rst = 1'b0;
        tick();
        s_chk("idle_req_ready", 64'(req_ready), 64'd0);

        // Requester 0 first after reset: 3 x 5
        exp_q.push_back('{0, 64'd15});
        req_a[31:0] = 32'd3;
        req_b[31:0] = 32'd5;
        req_valid = 2'b01;
        #1;
        s_chk("first_ready0", 64'(req_ready), 64'b01);
        wait_acc(1, 20);
        req_valid = '0;
        s_chk("load_mul_on", 64'(mul_on), 64'd1);
        s_chk("load_mul_a",  64'(mul_a), 64'd3);
        s_chk("load_mul_b",  64'(mul_b), 64'd5);
        s_chk("load_ready",  64'(req_ready), 64'd0);
        tick();
        s_chk("run_mul_on",  64'(mul_on), 64'd0);
        wait_rsp(1, 80);

        // Requester 1, full-scale operands
        single(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        // Both requesters continuously valid: strict alternation 0,1,0,1
        exp_q.push_back('{0, 64'd14});
        exp_q.push_back('{1, 64'd54});
        exp_q.push_back('{0, 64'd14});
        exp_q.push_back('{1, 64'd54});
        req_a = {32'd6, 32'd2};
        req_b = {32'd9, 32'd7};
        ba = n_acc;
        br = n_rsp;
        period_chk = 1;
        req_valid = 2'b11;
        wait_acc(ba + 4, 200);
        req_valid = '0;
        wait_rsp(br + 4, 100);
        period_chk = 0;

        // Back-pressure on requester 0 while requester 1 waits
        exp_q.push_back('{0, 64'd40});
        exp_q.push_back('{1, 64'd25});
        req_a = {32'd5, 32'd10};
        req_b = {32'd5, 32'd4};
        rsp_ready = 2'b10;
        ba = n_acc;
        br = n_rsp;
        req_valid = 2'b11;
        wait_acc(ba + 1, 20);
        req_valid[0] = 1'b0;
        b = 80;
        while (!rsp_valid[0] && b > 0) begin
            tick();
            b--;
        end
        s_chk("hold_seen", 64'(rsp_valid[0]), 64'd1);
        for (int k = 0; k < 10; k++) begin
            s_chk("hold_valid", 64'(rsp_valid), 64'b01);
            s_chk("hold_data",  rsp_data, 64'd40);
            s_chk("hold_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = '1;
        wait_acc(ba + 2, 20);
        req_valid = '0;
        wait_rsp(br + 2, 100);

        // Zero operands keep full latency
        single(0, 32'd123, 32'd0, 64'd0);
        single(1, 32'd0, 32'd77, 64'd0);

        // Reset in RUN cycle 10 abandons the job
        req_a[31:0] = 32'd9;
        req_b[31:0] = 32'd9;
        ba = n_acc;
        br = n_rsp;
        req_valid = 2'b01;
        wait_acc(ba + 1, 20);
        req_valid = '0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            seen = seen | (|rsp_valid);
            tick();
        end
        s_chk("abort_no_valid", 64'(seen), 64'd0);
        s_chk("abort_rsp_count", 64'(n_rsp), 64'(br));
        single(0, 32'd8, 32'd8, 64'd64);

        s_chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", s_pass + m_pass, s_tot + m_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_sched.md
# mul_sched

Round-robin scheduler that shares one 32x32 shift-and-add `multiplier` core between `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and pulses the core's `on` input to load it. It waits out the core's worst-case iteration count, then returns the 64-bit product on a per-requester valid/ready response channel. It sits between the requester blocks and the multiplier core, which is instantiated alongside it at the same level.

## Interface
- `NREQ`, 2: number of requesters, ≥2.
- `WIDTH`, 32: operand width; must equal the core width (32).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: request valid, one bit per requester.
- `req_ready`  out  NREQ: one-hot accept; an operand transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_a`  in  NREQ*WIDTH: multiplicand of requester i at bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH: multiplier of requester i, same packing.
- `rsp_valid`  out  NREQ: one-hot; product ready for requester i.
- `rsp_ready`  in  NREQ: response accept.
- `rsp_data`  out  2*WIDTH: product; shared by all requesters, qualified by `rsp_valid`.
- `mul_on`  out  1: drives core `on`.
- `mul_a`, `mul_b`  out  WIDTH: drive core `A`, `B`.
- `mul_out`  in  2*WIDTH: core `out`.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- **IDLE**
  - If any `req_valid` is set, grant g is the first set bit searching upward from `last_grant+1` (mod NREQ).
  - `req_ready[g]=1` combinationally; all other `req_ready` bits are 0.
  - On the accepting edge: latch `req_a[g]`/`req_b[g]` into `mul_a`/`mul_b`, register g, go to LOAD.
  - With no request pending, stay in IDLE.
- **LOAD**
  - `mul_on=1` for exactly this one cycle.
  - On exit: `cnt<=WIDTH`, go to RUN.
- **RUN**
  - `cnt` decrements each cycle.
  - In the cycle where `cnt==0`: capture `mul_out` into `rsp_data`, go to RESP.
  - The wait is fixed at WIDTH core iterations, independent of B; the core is idle-stable after its multiplier register reaches 0.
- **RESP**
  - `rsp_valid[g]=1`; `rsp_data` is held stable.
  - On `rsp_ready[g]`: `last_grant<=g`, go to IDLE.
  - `rsp_ready` bits for requesters other than g are ignored.
- `req_ready` is all-zero outside IDLE. A requester may hold `req_valid` arbitrarily long; it is not dropped.
- Arithmetic: unsigned 32x32→64, no truncation. The product is formed entirely by the core; the scheduler performs no arithmetic apart from `cnt`.
- Reset values:
  - state IDLE, `last_grant=NREQ-1` (requester 0 wins first).
  - `rsp_valid=0`, `rsp_data=0`, `mul_on=0`, `mul_a=0`, `mul_b=0`, `cnt=0`.
- Reset mid-operation: the job is abandoned and no response is issued. The core has no reset; the next LOAD fully reinitialises it.
- Simultaneous requests: exactly one is granted per IDLE visit, with strict rotation, so no requester waits more than NREQ-1 jobs.

## Timing
- Accept edge Ea (in IDLE) → LOAD occupies cycle Ea+1 → core loads at edge Ea+1.
- RUN occupies WIDTH+1 cycles; capture happens at edge Ea+WIDTH+2.
- `rsp_valid` is high in the cycle after edge Ea+WIDTH+2, i.e. 34 clocks after accept when WIDTH=32.
- Minimum job period with `rsp_ready` held high is WIDTH+4 = 36 cycles: IDLE 1, LOAD 1, RUN 33, RESP 1.
- `mul_a`/`mul_b` are stable from LOAD until the next accept.

## Structure
- Package `mul_pkg`:
  - state enum typedef (IDLE/LOAD/RUN/RESP);
  - `MUL_WIDTH=32`;
  - `MUL_WAIT=MUL_WIDTH` iteration constant;
  - counter width `$clog2(MUL_WIDTH+1)`.
- Sub-module `rr_arbiter`: combinational round-robin pick, taking `req_valid` and `last_grant` and producing a one-hot grant and its index. Parameterised by NREQ.
- The multiplier core is not instantiated inside `mul_sched`.

## Test plan
- Req0 A=3, B=5 from reset, `rsp_ready` high → `req_ready[0]` on first cycle; `rsp_valid[0]` 34 cycles later, `rsp_data=64'd15`.
- Req1 A=B=32'hFFFFFFFF → `rsp_valid[1]`, `rsp_data=64'hFFFFFFFE00000001`.
- Both requesters valid continuously, req0 (2×7) and req1 (6×9) → grants alternate 0,1,0,1; responses 14, 54, 14, 54, each 36 cycles apart.
- Req0 A=10, B=4 with `rsp_ready[0]=0` for 10 cycles while req1 is valid → `rsp_valid[0]` and `rsp_data=40` held for 10 cycles; `req_ready` stays 0 until `rsp_ready[0]` rises.
- B=0 (A=123) and A=0 (B=77) → `rsp_data=0`, with latency still 34.
- Assert `rst` in RUN cycle 10 of a 9×9 job → no `rsp_valid`; a following req0 8×8 returns 64 with normal latency.
